mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline IF stage (instruction fetch) and the
//  MEM stage (lw/sw). It runs a req/ack protocol with each stage, sequences fixed-latency memory
//  accesses and drives stall requests to the hazard unit. The data port wins by default, because
//  MEM holds the older instruction. A streak limit prevents IF starvation.
// PARAMETERS
//  MEM_LATENCY    2   cycles from the mem_en cycle to the mem_rdata valid cycle; legal range >=1
//  MAX_D_STREAK   4   consecutive data grants allowed while if_req is pending before IF is forced in; >=1
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-low reset
//  if_req     in   1   fetch request; held until if_ack
//  if_addr    in   32  fetch byte address
//  if_ack     out  1   1-cycle pulse; if_rdata valid in the same cycle
//  if_rdata   out  32  fetched instruction
//  d_req      in   1   data request; held until d_ack
//  d_we       in   1   1=store (sw), 0=load (lw)
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data
//  d_ack      out  1   1-cycle pulse; d_rdata valid in the same cycle (loads only)
//  d_rdata    out  32  load data
//  mem_en     out  1   1-cycle access strobe to memory
//  mem_we     out  1   write enable, qualified by mem_en
//  mem_addr   out  32  memory address (latched request address, passed unchanged)
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  read data, valid exactly MEM_LATENCY cycles after the mem_en cycle
//  stall_if   out  1   comb: if_req & ~if_ack
//  stall_mem  out  1   comb: d_req & ~d_ack
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (reset==0 at a posedge): state=IDLE. All registered outputs, latched command and counters go to 0.
//    Any in-flight access is abandoned and its late mem_rdata is ignored. stall_* still follow req.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//    IDLE: at a posedge with any req, pick the owner, latch addr/we/wdata, go to ISSUE.
//    ISSUE: mem_en=1 (and mem_we=we when the owner is data) for exactly one cycle; load the latency counter; go to WAIT.
//    WAIT: count MEM_LATENCY-1 further cycles. In the cycle where mem_rdata is valid, capture it and go to RESP.
//    RESP: the owner's ack=1 for one cycle; rdata holds the captured word (0 for stores); go to IDLE.
//  - Latency: request sampled at edge T -> ack high in cycle T+MEM_LATENCY+2. One request is in flight at a time.
//  - The requester drops or changes req at the edge that ends its ack cycle. Because RESP->IDLE, that
//    request is never served twice.
//  - Selection in IDLE:
//    only one req -> grant that port.
//    both reqs and streak<MAX_D_STREAK -> grant data and increment streak.
//    both reqs and streak==MAX_D_STREAK -> grant IF.
//  - streak clears on any IF grant, and in any IDLE cycle with if_req==0.
//  - streak is $clog2(MAX_D_STREAK+1) bits wide and saturates; it never wraps.
//  - rdata outputs hold their last value outside ack. The non-owner ack is always 0.
//  - The latched command is immune to request changes after the grant edge.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs if_wait_cnt[31:0], d_wait_cnt[31:0] and conflict_cnt[31:0].
//    if_wait_cnt and d_wait_cnt increment every cycle that stall_if or stall_mem is high.
//    conflict_cnt increments on every IDLE grant where both reqs are high.
//    All three are 0 at reset and wrap modulo 2^32.
//  ARB_STATS_EN undefined: the counters and ports do not exist, and arbitration is identical.
// TESTING
//  1 Reset mid-WAIT, then re-request -> no stale ack; fresh ack at T+MEM_LATENCY+2.
//  2 Lone if_req, addr 0x10, mem word 0x00500093, MEM_LATENCY=2.
//    -> mem_en in cycle T+1, if_ack + if_rdata=0x00500093 in T+4; stall_if high T..T+3.
//  3 d_req with we=1, addr 0x40, wdata 0x64, then a load of 0x40.
//    -> mem_we pulse with mem_wdata=0x64; second ack returns d_rdata=0x64.
//  4 if_req and d_req both asserted in the same cycle -> data granted first; IF acked at the next grant.
//  5 if_req held with a continuous d_req stream, MAX_D_STREAK=4 -> grants D,D,D,D,IF,D...;
//    IF acked within 5 transactions.
//  6 (ARB_STATS_EN) Case 4 -> conflict_cnt=1.
//    if_wait_cnt equals the cycles stall_if was high, counted from the first if_req cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access with fixed latency.
// Optional ARB_STATS_EN adds stall-cycle and conflict counters.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
`ifdef ARB_STATS_EN
  output logic [31:0] if_wait_cnt,
  output logic [31:0] d_wait_cnt,
  output logic [31:0] conflict_cnt,
`endif
  output logic        busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic            owner_d_reg;
  logic            we_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     wdata_reg;
  logic [CW-1:0]   lat_reg;
  logic [SW-1:0]   streak_reg, streak_next;
  logic [31:0]     if_rdata_reg;
  logic [31:0]     d_rdata_reg;

  logic both_req;
  logic any_req;
  logic grant_d;
  logic capture;

  assign both_req = if_req & d_req;
  assign any_req  = if_req | d_req;
  // Data wins a conflict until it has taken MAX_D_STREAK grants in a row.
  assign grant_d  = d_req & (~if_req | (streak_reg < SW'(MAX_D_STREAK)));
  assign capture  = (state_reg == WAIT) && (lat_reg == '0);

  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ISSUE;
        if (!if_req) streak_next = '0;
        else if (both_req && grant_d) streak_next = streak_reg + SW'(1);
        else streak_next = '0;
      end
      ISSUE: state_next = WAIT;
      WAIT:  if (lat_reg == '0) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      owner_d_reg  <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      lat_reg      <= '0;
      streak_reg   <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      if (state_reg == IDLE && any_req) begin
        owner_d_reg <= grant_d;
        addr_reg    <= grant_d ? d_addr : if_addr;
        we_reg      <= grant_d & d_we;
        wdata_reg   <= grant_d ? d_wdata : '0;
      end
      if (state_reg == ISSUE)
        lat_reg <= CW'(MEM_LATENCY - 1);
      else if (state_reg == WAIT && lat_reg != '0)
        lat_reg <= lat_reg - CW'(1);
      if (capture) begin
        if (owner_d_reg) d_rdata_reg  <= we_reg ? '0 : mem_rdata;
        else             if_rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign if_ack    = (state_reg == RESP) & ~owner_d_reg;
  assign d_ack     = (state_reg == RESP) & owner_d_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  assign busy      = (state_reg != IDLE);

`ifdef ARB_STATS_EN
  logic [31:0] if_wait_reg, d_wait_reg, conflict_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_wait_reg  <= '0;
      d_wait_reg   <= '0;
      conflict_reg <= '0;
    end else begin
      if (stall_if)  if_wait_reg <= if_wait_reg + 32'd1;
      if (stall_mem) d_wait_reg  <= d_wait_reg + 32'd1;
      if (state_reg == IDLE && both_req) conflict_reg <= conflict_reg + 32'd1;
    end
  end

  assign if_wait_cnt  = if_wait_reg;
  assign d_wait_cnt   = d_wait_reg;
  assign conflict_cnt = conflict_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus a memory model.
module tb_mem_port_arbiter;
  localparam int L    = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
`ifdef ARB_STATS_EN
  logic [31:0] if_wait_cnt, d_wait_cnt, conflict_cnt;
  logic [31:0] m_ifw = 0, m_dw = 0, m_conf = 0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_STATS_EN
    .if_wait_cnt(if_wait_cnt), .d_wait_cnt(d_wait_cnt), .conflict_cnt(conflict_cnt),
`endif
    .busy(busy)
  );

  int checks = 0, errors = 0;

  // Transaction model: one access at a time, timing derived from the grant cycle.
  int          cyc = 0;
  int          free_cyc = 0, busy_start = 0, memen_cyc = -1, ack_cyc = -1;
  bit          own_d = 0, t_we = 0;
  logic [31:0] t_addr = 0, t_wdata = 0, t_data = 0;
  logic [31:0] last_if = 0, last_d = 0;
  int          streak = 0;
  bit          if_acked = 0, d_acked = 0;
  int          n_iack = 0, n_dack = 0;
  int          p_if = 0, p_d = 0;
  logic [31:0] env_mem [32];
  logic [31:0] ref_mem [32];
  int          rd_due [$];
  logic [31:0] rd_val [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31)) << 2;
    return a;
  endfunction

  task automatic update_reqs();
    if (if_acked) if_req = 1'b0;
    if (d_acked)  d_req  = 1'b0;
    // Owner's inputs change after the grant; the latched command must not follow them.
    if (ack_cyc >= 0 && cyc >= busy_start && cyc < ack_cyc) begin
      if (own_d) begin d_addr = rand_addr(); d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); end
      else if_addr = rand_addr();
    end
    if (!if_req && $urandom_range(0, 99) < p_if) begin
      if_req = 1'b1; if_addr = rand_addr();
    end
    if (!d_req && $urandom_range(0, 99) < p_d) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
    end
  endtask

  task automatic step();
    bit ai, ad, gd;
    @(negedge clk);
    ai = (cyc == ack_cyc) && !own_d;
    ad = (cyc == ack_cyc) && own_d;
    if (cyc == memen_cyc) begin
      if (t_we) begin ref_mem[t_addr[6:2]] = t_wdata; t_data = 0; end
      else t_data = ref_mem[t_addr[6:2]];
    end
    if (ai) last_if = t_data;
    if (ad) last_d = t_data;

    check_eq("if_ack", {31'b0, if_ack}, {31'b0, ai});
    check_eq("d_ack", {31'b0, d_ack}, {31'b0, ad});
    check_eq("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~ai});
    check_eq("stall_mem", {31'b0, stall_mem}, {31'b0, d_req & ~ad});
    check_eq("busy", {31'b0, busy}, {31'b0, (cyc >= busy_start) && (cyc < free_cyc)});
    check_eq("mem_en", {31'b0, mem_en}, {31'b0, cyc == memen_cyc});
    if (cyc == memen_cyc) begin
      check_eq("mem_addr", mem_addr, t_addr);
      check_eq("mem_we", {31'b0, mem_we}, {31'b0, t_we});
      if (t_we) check_eq("mem_wdata", mem_wdata, t_wdata);
    end
    check_eq("if_rdata", if_rdata, last_if);
    check_eq("d_rdata", d_rdata, last_d);
`ifdef ARB_STATS_EN
    check_eq("if_wait_cnt", if_wait_cnt, m_ifw);
    check_eq("d_wait_cnt", d_wait_cnt, m_dw);
    check_eq("conflict_cnt", conflict_cnt, m_conf);
    if (!reset) begin m_ifw = 0; m_dw = 0; m_conf = 0; end
    else begin
      if (if_req && !ai) m_ifw++;
      if (d_req && !ad) m_dw++;
    end
`endif
    if (if_ack) n_iack++;
    if (d_ack)  n_dack++;
    if (ai || ad)
      $display("txn cyc=%0d port=%s addr=%h we=%0d data=%h", cyc, ad ? "D " : "IF", t_addr, t_we, t_data);
    if_acked = ai;
    d_acked  = ad;

    // Memory environment reacts to what the DUT actually drives.
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[6:2]] = mem_wdata;
      else begin rd_due.push_back(cyc + L); rd_val.push_back(env_mem[mem_addr[6:2]]); end
    end

    if (!reset) begin
      streak = 0; free_cyc = cyc + 1; busy_start = cyc + 1;
      memen_cyc = -1; ack_cyc = -1; last_if = 0; last_d = 0;
    end else if (cyc >= free_cyc) begin
      if (!if_req) streak = 0;
      if (if_req || d_req) begin
        if (if_req && d_req) begin
`ifdef ARB_STATS_EN
          m_conf++;
`endif
          if (streak < MAXS) begin gd = 1; streak++; end
          else begin gd = 0; streak = 0; end
        end else if (if_req) begin
          gd = 0; streak = 0;
        end else gd = 1;
        own_d   = gd;
        t_addr  = gd ? d_addr : if_addr;
        t_we    = gd && d_we;
        t_wdata = d_wdata;
        memen_cyc = cyc + 1; busy_start = cyc + 1;
        ack_cyc = cyc + L + 2; free_cyc = cyc + L + 3;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    while (rd_due.size() > 0 && rd_due[0] < cyc) begin
      void'(rd_due.pop_front()); void'(rd_val.pop_front());
    end
    if (rd_due.size() > 0 && rd_due[0] == cyc) mem_rdata = rd_val[0];
    else mem_rdata = $urandom;
    update_reqs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    p_if = 0; p_d = 0;
    while ((if_req || d_req || cyc < free_cyc) && n < budget) begin
      step(); n++;
    end
    check_eq("drain_idle", {31'b0, if_req | d_req}, 32'd0);
  endtask

  task automatic req_if(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic wait_if_ack(input int budget);
    int n = 0;
    int i0 = n_iack;
    while (n_iack == i0 && n < budget) begin step(); n++; end
    check_eq("if_ack_seen", n_iack - i0, 1);
  endtask

  initial begin
    int d0;
    reset = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    for (int i = 0; i < 32; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    @(posedge clk); #1; cyc = 1;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Lone fetch of a known instruction word.
    env_mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    req_if(32'h10);
    drain(50);
    check_eq("t2_if_rdata", if_rdata, 32'h00500093);

    // Store then load the same word.
    req_d(1'b1, 32'h40, 32'h64);
    drain(50);
    req_d(1'b0, 32'h40, 32'h0);
    drain(50);
    check_eq("t3_load", d_rdata, 32'h64);

    // Reset in the middle of WAIT, request stays up.
    d0 = n_dack;
    req_d(1'b0, 32'h20, 32'h0);
    step(); step();
    reset = 1'b0; step(); reset = 1'b1;
    drain(50);
    check_eq("t1_single_ack", n_dack - d0, 1);

    // Simultaneous requests: data goes first.
    d0 = n_dack;
    req_if(32'h08); req_d(1'b0, 32'h0C, 32'h0);
    wait_if_ack(50);
    check_eq("t4_d_before_if", n_dack - d0, 1);
    drain(50);

    // Held fetch against a continuous data stream.
    d0 = n_dack;
    p_d = 100;
    req_if(32'h04); req_d(1'b0, 32'h30, 32'h0);
    wait_if_ack(100);
    check_eq("t5_d_before_if", n_dack - d0, MAXS);
    drain(100);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      p_if = 40; p_d = 50;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
